// File: rtl/serial_tx.sv
// Start/data/stop serial transmitter with valid/ready input handshake.
// Data goes out LSB first; each bit is held for CLKS_PER_BIT clocks.
module serial_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  tx_line,
    output logic                  busy
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t                r_state;
    logic [CW-1:0]         r_cnt;
    logic [IW-1:0]         r_idx;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_line;
    logic [DATA_WIDTH-1:0] w_shift_next;
    logic                  w_bit_done;

    assign w_shift_next = r_shift >> 1;
    assign w_bit_done   = (r_cnt == LAST_CNT);

    assign tx_ready = (r_state == IDLE) && !reset;
    assign busy     = (r_state != IDLE);
    assign tx_line  = r_line;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_line  <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    r_idx <= '0;
                    if (tx_valid) begin
                        r_shift <= tx_data;
                        r_state <= START;
                        r_line  <= 1'b0;
                    end
                end
                START: begin
                    if (w_bit_done) begin
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_state <= DATA;
                        r_line  <= r_shift[0];
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (w_bit_done) begin
                        r_cnt   <= '0;
                        r_shift <= w_shift_next;
                        if (r_idx == LAST_IDX) begin
                            r_idx   <= '0;
                            r_state <= STOP;
                            r_line  <= 1'b1;
                        end else begin
                            r_idx  <= r_idx + IW'(1);
                            r_line <= w_shift_next[0];
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                STOP: begin
                    r_line <= 1'b1;
                    if (w_bit_done) begin
                        r_cnt   <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_line  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: frame vectors, corner sequences and a random run
// against a cycle-count frame model; a second instance uses one clock per bit.
module tb_serial_tx;

    localparam int CA = 4;
    localparam int FR = 10 * CA;

    logic       clk;
    logic       rst_a, rst_b;
    logic [7:0] data_a, data_b;
    logic       valid_a, valid_b;
    logic       tx_ready_a, tx_line_a, busy_a;
    logic       tx_ready_b, tx_line_b, busy_b;

    int checks;
    int failures;

    bit         m_act;
    int         m_el;
    logic [7:0] m_w;

    serial_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CA)) u_a (
        .clock(clk), .reset(rst_a), .tx_data(data_a), .tx_valid(valid_a),
        .tx_ready(tx_ready_a), .tx_line(tx_line_a), .busy(busy_a)
    );

    serial_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(1)) u_b (
        .clock(clk), .reset(rst_b), .tx_data(data_b), .tx_valid(valid_b),
        .tx_ready(tx_ready_b), .tx_line(tx_line_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       poke;
        logic [7:0] poke_data;
        logic [9:0] pat;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Frame bit n is held for CA cycles: 0 = start, 1..8 = data, 9 = stop.
    function automatic logic m_line();
        int b;
        if (!m_act) return 1'b1;
        b = m_el / CA;
        if (b == 0) return 1'b0;
        if (b <= 8) return m_w[b-1];
        return 1'b1;
    endfunction

    task automatic step();
        bit         hs;
        logic [7:0] d;
        hs = valid_a && !m_act && !rst_a;
        d  = data_a;
        @(posedge clk);
        if (m_act) begin
            m_el++;
            if (m_el == FR) m_act = 0;
        end
        if (hs) begin
            m_act = 1;
            m_el  = 0;
            m_w   = d;
        end
        #1;
        chk("model_line", tx_line_a, m_line());
        chk("model_ready", tx_ready_a, int'(!m_act && !rst_a));
        chk("model_busy", busy_a, int'(m_act));
    endtask

    task automatic run_vec(input int id, input vec_t v);
        logic       obs[FR];
        logic [3:0] s;
        int         low;
        data_a  = v.data;
        valid_a = 1'b1;
        step();
        valid_a = 1'b0;
        obs[0]  = tx_line_a;
        low     = int'(!tx_ready_a);
        for (int i = 1; i < FR; i++) begin
            if (v.poke && i == 10) data_a = v.poke_data;
            step();
            obs[i] = tx_line_a;
            low += int'(!tx_ready_a);
        end
        for (int b = 0; b < 10; b++) begin
            for (int j = 0; j < CA; j++) s[j] = obs[CA*b+j];
            chk($sformatf("vec%0d_bit%0d", id, b), s, v.pat[b] ? 15 : 0);
        end
        chk($sformatf("vec%0d_ready_low", id), low, FR);
        step();
        chk($sformatf("vec%0d_post_ready", id), tx_ready_a, 1);
        chk($sformatf("vec%0d_post_line", id), tx_line_a, 1);
    endtask

    initial begin
        logic       ob[82];
        logic       rb[82];
        logic [9:0] p1, p2;
        int         nidle, nready;
        vec_t       v42;

        checks   = 0;
        failures = 0;
        m_act    = 0;
        m_el     = 0;
        m_w      = '0;
        rst_a    = 1'b1;
        rst_b    = 1'b1;
        data_a   = '0;
        data_b   = '0;
        valid_a  = 1'b0;
        valid_b  = 1'b0;

        vecs[0] = '{8'hA5, 1'b0, 8'h00, 10'b1101001010};
        vecs[1] = '{8'h00, 1'b1, 8'hFF, 10'b1000000000};
        vecs[2] = '{8'hFF, 1'b0, 8'h00, 10'b1111111110};
        vecs[3] = '{8'h81, 1'b1, 8'h7E, 10'b1100000010};
        v42     = '{8'h42, 1'b0, 8'h00, 10'b1010000100};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_line", tx_line_a, 1);
        chk("rst_busy", busy_a, 0);
        chk("rst_ready", tx_ready_a, 0);
        chk("rst_b_ready", tx_ready_b, 0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        #1;
        chk("ready_after_rst", tx_ready_a, 1);

        nidle = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (tx_line_a !== 1'b1 || busy_a !== 1'b0 || tx_ready_a !== 1'b1)
                nidle++;
        end
        chk("idle50_bad_cycles", nidle, 0);

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // Back-to-back: valid held, second word presented after first handshake.
        p1 = 10'b1001111000;
        p2 = 10'b1111111110;
        data_a  = 8'h3C;
        valid_a = 1'b1;
        step();
        data_a = 8'hFF;
        ob[0]  = tx_line_a;
        rb[0]  = tx_ready_a;
        for (int i = 1; i <= 81; i++) begin
            step();
            ob[i] = tx_line_a;
            rb[i] = tx_ready_a;
            if (i == 41) valid_a = 1'b0;
        end
        nidle  = 0;
        nready = 0;
        for (int i = 0; i < FR; i++) begin
            if (ob[i] !== p1[i/CA]) nidle++;
            if (ob[i+41] !== p2[i/CA]) nidle++;
        end
        for (int i = 0; i <= 80; i++) nready += int'(rb[i]);
        chk("b2b_bit_errors", nidle, 0);
        chk("b2b_ready_cycles", nready, 1);
        chk("b2b_ready_slot", rb[40], 1);
        chk("b2b_second_start", ob[41], 0);
        chk("b2b_end_ready", rb[81], 1);

        // Reset 13 cycles into a frame, between edges.
        data_a  = 8'h81;
        valid_a = 1'b1;
        step();
        valid_a = 1'b0;
        repeat (12) step();
        chk("pre_rst_busy", busy_a, 1);
        #2;
        rst_a = 1'b1;
        m_act = 0;
        #1;
        chk("midrst_line", tx_line_a, 1);
        chk("midrst_busy", busy_a, 0);
        chk("midrst_ready", tx_ready_a, 0);
        valid_a = 1'b1;
        repeat (2) step();
        valid_a = 1'b0;
        #2;
        rst_a = 1'b0;
        #1;
        chk("postrst_ready", tx_ready_a, 1);
        chk("postrst_line", tx_line_a, 1);
        run_vec(4, v42);

        for (int i = 0; i < 500; i++) begin
            data_a  = 8'($urandom);
            valid_a = ($urandom_range(0, 3) == 0);
            step();
        end
        valid_a = 1'b0;
        repeat (FR + 2) step();
        chk("rand_end_idle", busy_a, 0);

        // One clock per bit.
        data_b  = 8'h01;
        valid_b = 1'b1;
        @(posedge clk);
        #1;
        valid_b = 1'b0;
        p1      = 10'b1000000010;
        nidle   = 0;
        nready  = 0;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            if (tx_line_b !== p1[i]) nidle++;
            nready += int'(tx_ready_b);
        end
        chk("c1_bit_errors", nidle, 0);
        chk("c1_ready_during", nready, 0);
        @(posedge clk);
        #1;
        chk("c1_ready_after", tx_ready_b, 1);
        chk("c1_line_after", tx_line_b, 1);
        chk("c1_busy_after", busy_b, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
